// File: rtl/tri_dispatch.sv
// Triangle dispatch queue: buffers upstream triangles and hands them one at a time to a busy-handshaking rasterizer.
// Optional back-face/degenerate culling when TRI_DISPATCH_CULL_EN is defined.
module tri_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_s_valid,
    output logic                         o_s_ready,
    input  logic signed [15:0]           i_s_x0,
    input  logic signed [15:0]           i_s_y0,
    input  logic signed [15:0]           i_s_x1,
    input  logic signed [15:0]           i_s_y1,
    input  logic signed [15:0]           i_s_x2,
    input  logic signed [15:0]           i_s_y2,
    input  logic [7:0]                   i_s_z0,
    input  logic [7:0]                   i_s_z1,
    input  logic [7:0]                   i_s_z2,
    input  logic [31:0]                  i_s_u0,
    input  logic [31:0]                  i_s_v0,
    input  logic [31:0]                  i_s_u1,
    input  logic [31:0]                  i_s_v1,
    input  logic [31:0]                  i_s_u2,
    input  logic [31:0]                  i_s_v2,
    output logic                         o_tri_valid,
    input  logic                         i_busy,
    output logic signed [15:0]           o_x0,
    output logic signed [15:0]           o_y0,
    output logic signed [15:0]           o_x1,
    output logic signed [15:0]           o_y1,
    output logic signed [15:0]           o_x2,
    output logic signed [15:0]           o_y2,
    output logic [7:0]                   o_z0,
    output logic [7:0]                   o_z1,
    output logic [7:0]                   o_z2,
    output logic [31:0]                  o_u0,
    output logic [31:0]                  o_v0,
    output logic [31:0]                  o_u1,
    output logic [31:0]                  o_v1,
    output logic [31:0]                  o_u2,
    output logic [31:0]                  o_v2,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
`ifdef TRI_DISPATCH_CULL_EN
    output logic [15:0]                  o_cull_cnt,
`endif
    output logic                         o_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic signed [15:0] x0, y0, x1, y1, x2, y2;
        logic [7:0]         z0, z1, z2;
        logic [31:0]        u0, v0, u1, v1, u2, v2;
    } tri_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    tri_t            r_mem [DEPTH];
    tri_t            r_out;
    tri_t            w_in;
    state_t          r_state;
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_tri_valid;
    logic            w_xfer, w_push, w_pop;

    assign w_in = {i_s_x0, i_s_y0, i_s_x1, i_s_y1, i_s_x2, i_s_y2,
                   i_s_z0, i_s_z1, i_s_z2,
                   i_s_u0, i_s_v0, i_s_u1, i_s_v1, i_s_u2, i_s_v2};

    assign o_s_ready = (r_count < CW'(DEPTH));
    assign w_xfer    = i_s_valid && o_s_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

`ifdef TRI_DISPATCH_CULL_EN
    logic signed [31:0] w_dx1, w_dy1, w_dx2, w_dy2, w_area;
    logic [15:0]        r_cull_cnt;

    assign w_dx1  = 32'(i_s_x1) - 32'(i_s_x0);
    assign w_dy1  = 32'(i_s_y1) - 32'(i_s_y0);
    assign w_dx2  = 32'(i_s_x2) - 32'(i_s_x0);
    assign w_dy2  = 32'(i_s_y2) - 32'(i_s_y0);
    assign w_area = (w_dx1 * w_dy2) - (w_dx2 * w_dy1);
    // Only strictly negative area survives; zero-area and back-facing are consumed silently.
    assign w_push = w_xfer && w_area[31];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cull_cnt <= '0;
        else if (w_xfer && !w_area[31] && (r_cull_cnt != 16'hFFFF))
            r_cull_cnt <= r_cull_cnt + 1'b1;
    end
    assign o_cull_cnt = r_cull_cnt;
`else
    assign w_push = w_xfer;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_in;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The held triangle only reloads on an IDLE pop, so it is stable for the whole rasterization.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tri_valid <= 1'b0;
            r_out       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tri_valid <= 1'b0;
                    if (w_pop) begin
                        r_out       <= r_mem[r_rptr];
                        r_tri_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tri_valid <= 1'b0;
                    r_state     <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_tri_valid <= 1'b0;
                    if (i_busy) r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    r_tri_valid <= 1'b0;
                    if (!i_busy) r_state <= S_IDLE;
                end
                default: begin
                    r_tri_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tri_valid = r_tri_valid;
    assign o_count     = r_count;
    assign o_idle      = (r_state == S_IDLE) && (r_count == '0);

    assign o_x0 = r_out.x0;
    assign o_y0 = r_out.y0;
    assign o_x1 = r_out.x1;
    assign o_y1 = r_out.y1;
    assign o_x2 = r_out.x2;
    assign o_y2 = r_out.y2;
    assign o_z0 = r_out.z0;
    assign o_z1 = r_out.z1;
    assign o_z2 = r_out.z2;
    assign o_u0 = r_out.u0;
    assign o_v0 = r_out.v0;
    assign o_u1 = r_out.u1;
    assign o_v1 = r_out.v1;
    assign o_u2 = r_out.u2;
    assign o_v2 = r_out.v2;

endmodule

// File: doc/tri_dispatch.md
TRI_DISPATCH -- requirements
Module: tri_dispatch

Interface
REQ-001 Parameter: DEPTH, default 4, triangle FIFO entries (power of two, >= 2).
REQ-002 i_clk  input  1  clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_s_valid  input  1  upstream triangle valid.
REQ-005 o_s_ready  output  1  upstream may transfer; transfer when i_s_valid && o_s_ready.
REQ-006 i_s_x0,i_s_y0,i_s_x1,i_s_y1,i_s_x2,i_s_y2  input  16 each, signed  screen vertices.
REQ-007 i_s_z0,i_s_z1,i_s_z2  input  8 each  vertex depth.
REQ-008 i_s_u0,i_s_v0,i_s_u1,i_s_v1,i_s_u2,i_s_v2  input  32 each  vertex attributes.
REQ-009 o_tri_valid  output  1  start pulse to rasterizer.
REQ-010 i_busy  input  1  rasterizer busy.
REQ-011 o_x0..o_y2 (16 signed), o_z0..o_z2 (8), o_u0..o_v2 (32)  output  held triangle for rasterizer.
REQ-012 o_count  output  $clog2(DEPTH+1)  FIFO occupancy.
REQ-013 o_idle  output  1  FIFO empty and no triangle in flight.

Function
REQ-014 FIFO SHALL store the 312-bit triangle payload; push on upstream transfer, pop on dispatch.
REQ-015 o_s_ready SHALL be 1 iff o_count < DEPTH (registered count, no combinational path from i_busy).
REQ-016 Push and pop in same cycle SHALL leave o_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-017 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: if o_count > 0, load o_* from FIFO head, pop, go ISSUE; else stay.
REQ-019 ISSUE: o_tri_valid = 1 for exactly this one cycle; go WAIT_BUSY.
REQ-020 WAIT_BUSY: stay until i_busy = 1, then go WAIT_DONE.
REQ-021 WAIT_DONE: stay until i_busy = 0, then go IDLE.
REQ-022 o_x0..o_v2 SHALL be stable from ISSUE until return to IDLE; they change only on an IDLE pop.
REQ-023 Dispatch latency: triangle pushed into empty FIFO while IDLE -> o_tri_valid high 2 cycles after the push edge.
REQ-024 Minimum gap between consecutive o_tri_valid pulses = 1 cycle in IDLE after i_busy falls.
REQ-025 o_idle = (state == IDLE) && (o_count == 0).
REQ-026 Upstream transfers SHALL be accepted in every FSM state while not full.

Reset
REQ-027 On i_rst: state IDLE, pointers 0, o_count 0, o_tri_valid 0, o_s_ready 1 (after the reset cycle), o_idle 1, o_x0..o_v2 0.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight triangles; no o_tri_valid is emitted in the reset cycle or the cycle after.

Configuration
REQ-029 Macro TRI_DISPATCH_CULL_EN enables back-face/degenerate culling.
REQ-030 Culling uses the 32-bit signed value A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), computed on upstream inputs.
REQ-031 With macro defined: A >= 0 -> transfer accepted (ready-based) but not written; A < 0 -> pushed.
REQ-032 With macro defined: output o_cull_cnt, 16 bits, increments on each culled transfer, saturates at 0xFFFF, resets to 0.
REQ-033 Without macro: every transfer pushed; no o_cull_cnt port; no area logic.

Verification
REQ-034 Reset, push one triangle (0,0),(0,10),(10,0) z=5, hold i_busy 0 -> o_tri_valid pulses once at push+2; FSM stays in WAIT_BUSY; o_idle = 0.
REQ-035 Same triangle; drive i_busy 1 at pulse+1 for 20 cycles, then 0 -> o_* unchanged throughout; IDLE 1 cycle after the fall; o_idle = 1.
REQ-036 DEPTH=4: push 5 back-to-back with i_busy held 1 -> first pops; 4 queued; o_count = 4; o_s_ready = 0; 6th triangle stalled until the next pop.
REQ-037 FIFO at count 2, push and pop in same cycle -> o_count stays 2; dispatch order matches push order across pointer wrap (10 triangles).
REQ-038 CULL_EN: push clockwise (0,0),(10,0),(0,10) and collinear (0,0),(5,5),(10,10) -> both accepted; none dispatched; o_cull_cnt = 2.
REQ-039 Assert i_rst during WAIT_DONE with 3 queued -> o_count = 0, o_tri_valid = 0; no dispatch after i_busy falls.
